// File: rtl/pipe_stage_elastic_if.sv
// rtl/pipe_stage_elastic_if.sv - valid/ready bundle carrying data and control for pipe_stage_elastic
interface pipe_stage_elastic_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CTRL_WIDTH = 8
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [CTRL_WIDTH-1:0] ctrl;

  // Producer side: offers entries, observes ready
  modport master (
    output valid,
    output data,
    output ctrl,
    input  ready
  );

  // Consumer side: receives entries, drives ready
  modport slave (
    input  valid,
    input  data,
    input  ctrl,
    output ready
  );
endinterface

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic pipeline stage register; PIPE_STAGE_SKID_EN adds a registered-ready skid entry
module pipe_stage_elastic #(
  parameter int DATA_WIDTH = 16,
  parameter int CTRL_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  pipe_stage_elastic_if.slave  up,
  pipe_stage_elastic_if.master dn,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } state_t;

  state_t                state;
  state_t                state_nx;
  logic [DATA_WIDTH-1:0] main_data;
  logic [CTRL_WIDTH-1:0] main_ctrl;
  logic                  holding;
  logic                  pop;
  logic                  accept;
  logic                  ready_int;
  logic                  load_main_in;

  assign holding = (state != EMPTY);
  assign pop     = holding && dn.ready;
  assign accept  = up.valid && ready_int && !flush;

`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_WIDTH-1:0] skid_data;
  logic [CTRL_WIDTH-1:0] skid_ctrl;
  logic                  load_skid;
  logic                  load_main_skid;
  logic                  ready_q;

  // Registered ready: low only while the next state is FULL, so out_ready never reaches in_ready
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b1;
    end else begin
      ready_q <= (state_nx != FULL);
    end
  end

  // Reset masks the registered value so nothing is taken while rst is high
  assign ready_int = ready_q && !rst;
`else
  // Without a skid entry the stage can only take a new entry if the held one leaves this cycle
  assign ready_int = !rst && (!holding || dn.ready);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and storage load selection; flush overrides everything and drops the input
  always_comb begin
    state_nx     = state;
    load_main_in = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    load_skid      = 1'b0;
    load_main_skid = 1'b0;
`endif
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nx     = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && pop) begin
          load_main_in = 1'b1;
        end else if (pop) begin
          state_nx = EMPTY;
        end
`ifdef PIPE_STAGE_SKID_EN
        else if (accept) begin
          state_nx  = FULL;
          load_skid = 1'b1;
        end
`endif
      end
`ifdef PIPE_STAGE_SKID_EN
      FULL: begin
        if (pop) begin
          state_nx       = ONE;
          load_main_skid = 1'b1;
        end
      end
`endif
      default: begin
        state_nx = EMPTY;
      end
    endcase
    if (flush) begin
      state_nx     = EMPTY;
      load_main_in = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
      load_skid      = 1'b0;
      load_main_skid = 1'b0;
`endif
    end
  end

  // Outputs: control forced to zero on bubbles so no write-enable or halt leaks downstream
  always_comb begin
    dn.valid = holding;
    dn.data  = main_data;
    dn.ctrl  = holding ? main_ctrl : '0;
    up.ready = ready_int;
  end

  // Entry storage; main keeps its stale data when emptied or flushed
  always_ff @(posedge clk) begin
    if (rst) begin
      main_data <= '0;
      main_ctrl <= '0;
`ifdef PIPE_STAGE_SKID_EN
      skid_data <= '0;
      skid_ctrl <= '0;
`endif
    end else begin
      if (load_main_in) begin
        main_data <= up.data;
        main_ctrl <= up.ctrl;
      end
`ifdef PIPE_STAGE_SKID_EN
      else if (load_main_skid) begin
        main_data <= skid_data;
        main_ctrl <= skid_ctrl;
      end
      if (load_skid) begin
        skid_data <= up.data;
        skid_ctrl <= up.ctrl;
      end
`endif
    end
  end

  // Back-pressure counter: saturates, cleared only by reset (flush leaves it alone)
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (holding && !dn.ready && (stall_cnt != {CNT_WIDTH{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - self-checking bench for pipe_stage_elastic
module tb_pipe_stage_elastic;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        src_valid;
  logic [15:0] src_data;
  logic [7:0]  src_ctrl;
  logic        snk_ready;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  always #5 clk = ~clk;

  pipe_stage_elastic_if #(.DATA_WIDTH(16), .CTRL_WIDTH(8)) up_a ();
  pipe_stage_elastic_if #(.DATA_WIDTH(16), .CTRL_WIDTH(8)) dn_a ();
  pipe_stage_elastic_if #(.DATA_WIDTH(16), .CTRL_WIDTH(8)) up_b ();
  pipe_stage_elastic_if #(.DATA_WIDTH(16), .CTRL_WIDTH(8)) dn_b ();

  assign up_a.valid = src_valid;
  assign up_a.data  = src_data;
  assign up_a.ctrl  = src_ctrl;
  assign dn_a.ready = snk_ready;
  assign up_b.valid = src_valid;
  assign up_b.data  = src_data;
  assign up_b.ctrl  = src_ctrl;
  assign dn_b.ready = snk_ready;

  pipe_stage_elastic #(.DATA_WIDTH(16), .CTRL_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .up       (up_a),
    .dn       (dn_a),
    .stall_cnt(cnt_a)
  );

  pipe_stage_elastic #(.DATA_WIDTH(16), .CTRL_WIDTH(8), .CNT_WIDTH(4)) dut_sat (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .up       (up_b),
    .dn       (dn_b),
    .stall_cnt(cnt_b)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: the stage as an ordered queue of held entries
  typedef struct packed {
    logic [15:0] d;
    logic [7:0]  c;
  } ent_t;

  ent_t        q[$];
  logic [15:0] m_head = 16'h0;
  int          m_cnt  = 0;

  typedef struct {
    logic        r, f, v;
    logic [15:0] d;
    logic [7:0]  c;
    logic        o;
    logic        ev;
    logic [15:0] ed;
    logic [7:0]  ec;
    logic        er;
    logic [15:0] en;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_ready();
    if (rst) return 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || snk_ready;
`endif
  endfunction

  task automatic check_model();
    logic [7:0] ec;
    ec = 8'h00;
    if (q.size() != 0) ec = q[0].c;
    chk("out_valid", 32'(dn_a.valid), 32'(q.size() != 0));
    chk("out_data", 32'(dn_a.data), 32'(m_head));
    chk("out_ctrl", 32'(dn_a.ctrl), 32'(ec));
    chk("in_ready", 32'(up_a.ready), 32'(exp_ready()));
    chk("stall_cnt", 32'(cnt_a), 32'(m_cnt));
    chk("stall_cnt_sat", 32'(cnt_b), 32'((m_cnt > 15) ? 15 : m_cnt));
  endtask

  task automatic model_edge();
    logic acc;
    if (rst) begin
      q.delete();
      m_head = 16'h0;
      m_cnt  = 0;
    end else begin
      acc = src_valid && exp_ready() && !flush;
      if ((q.size() != 0) && !snk_ready && (m_cnt < 65535)) m_cnt++;
      if ((q.size() != 0) && snk_ready) void'(q.pop_front());
      if (flush) q.delete();
      else if (acc) q.push_back('{src_data, src_ctrl});
      if (q.size() != 0) m_head = q[0].d;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_model();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic f, input logic v, input logic [15:0] d,
                     input logic [7:0] c, input logic o, input logic ev, input logic [15:0] ed,
                     input logic [7:0] ec, input logic er, input logic [15:0] en);
    vec_t t;
    t.r = r; t.f = f; t.v = v; t.d = d; t.c = c; t.o = o;
    t.ev = ev; t.ed = ed; t.ec = ec; t.er = er; t.en = en;
    tbl.push_back(t);
  endtask

  initial begin
    // reset with an entry offered; it must never be taken
    add(1, 0, 1, 16'hBEEF, 8'h5A, 1, 0, 16'h0000, 8'h00, 0, 0);
    add(1, 0, 1, 16'hBEEF, 8'h5A, 1, 0, 16'h0000, 8'h00, 0, 0);
    add(0, 0, 0, 16'h0000, 8'h00, 1, 0, 16'h0000, 8'h00, 1, 0);
    // streaming 1..8
    for (int k = 1; k <= 8; k++) begin
      add(0, 0, 1, 16'(k), 8'(k), 1, (k > 1), 16'(k - 1), 8'(k - 1), 1, 0);
    end
    add(0, 0, 0, 16'h0000, 8'h00, 1, 1, 16'h0008, 8'h08, 1, 0);
    add(0, 0, 0, 16'h0000, 8'h00, 1, 0, 16'h0008, 8'h00, 1, 0);
`ifdef PIPE_STAGE_SKID_EN
    // back-pressure: two taken, third waits for the skid to drain
    add(0, 0, 1, 16'h0011, 8'h11, 0, 0, 16'h0008, 8'h00, 1, 0);
    add(0, 0, 1, 16'h0012, 8'h12, 0, 1, 16'h0011, 8'h11, 1, 0);
    add(0, 0, 1, 16'h0013, 8'h13, 0, 1, 16'h0011, 8'h11, 0, 1);
    add(0, 0, 1, 16'h0013, 8'h13, 0, 1, 16'h0011, 8'h11, 0, 2);
    add(0, 0, 1, 16'h0013, 8'h13, 1, 1, 16'h0011, 8'h11, 0, 3);
    add(0, 0, 1, 16'h0013, 8'h13, 1, 1, 16'h0012, 8'h12, 1, 3);
    add(0, 0, 0, 16'h0000, 8'h00, 1, 1, 16'h0013, 8'h13, 1, 3);
    add(0, 0, 0, 16'h0000, 8'h00, 1, 0, 16'h0013, 8'h00, 1, 3);
    // flush a full stage holding ctrl=FF with a new entry offered
    add(0, 0, 1, 16'h0021, 8'hFF, 0, 0, 16'h0013, 8'h00, 1, 3);
    add(0, 0, 1, 16'h0022, 8'hFF, 0, 1, 16'h0021, 8'hFF, 1, 3);
    add(0, 1, 1, 16'h0023, 8'hFF, 0, 1, 16'h0021, 8'hFF, 0, 4);
    add(0, 0, 0, 16'h0000, 8'h00, 1, 0, 16'h0021, 8'h00, 1, 5);
    add(0, 0, 0, 16'h0000, 8'h00, 1, 0, 16'h0021, 8'h00, 1, 5);
`else
    // back-pressure: in_ready follows out_ready in the same cycle
    add(0, 0, 1, 16'h0011, 8'h11, 0, 0, 16'h0008, 8'h00, 1, 0);
    add(0, 0, 1, 16'h0012, 8'h12, 0, 1, 16'h0011, 8'h11, 0, 0);
    add(0, 0, 1, 16'h0012, 8'h12, 0, 1, 16'h0011, 8'h11, 0, 1);
    add(0, 0, 1, 16'h0012, 8'h12, 1, 1, 16'h0011, 8'h11, 1, 2);
    add(0, 0, 1, 16'h0013, 8'h13, 1, 1, 16'h0012, 8'h12, 1, 2);
    add(0, 0, 0, 16'h0000, 8'h00, 1, 1, 16'h0013, 8'h13, 1, 2);
    add(0, 0, 0, 16'h0000, 8'h00, 1, 0, 16'h0013, 8'h00, 1, 2);
    // flush an occupied stage holding ctrl=FF with a new entry offered
    add(0, 0, 1, 16'h0021, 8'hFF, 0, 0, 16'h0013, 8'h00, 1, 2);
    add(0, 1, 1, 16'h0022, 8'hFF, 0, 1, 16'h0021, 8'hFF, 0, 2);
    add(0, 0, 0, 16'h0000, 8'h00, 1, 0, 16'h0021, 8'h00, 1, 3);
    add(0, 0, 0, 16'h0000, 8'h00, 1, 0, 16'h0021, 8'h00, 1, 3);
`endif

    rst       = 1'b1;
    flush     = 1'b0;
    src_valid = 1'b1;
    src_data  = 16'hBEEF;
    src_ctrl  = 8'h5A;
    snk_ready = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      rst       = tbl[i].r;
      flush     = tbl[i].f;
      src_valid = tbl[i].v;
      src_data  = tbl[i].d;
      src_ctrl  = tbl[i].c;
      snk_ready = tbl[i].o;
      @(negedge clk);
      chk($sformatf("vec%0d_out_valid", i), 32'(dn_a.valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_out_data", i), 32'(dn_a.data), 32'(tbl[i].ed));
      chk($sformatf("vec%0d_out_ctrl", i), 32'(dn_a.ctrl), 32'(tbl[i].ec));
      chk($sformatf("vec%0d_in_ready", i), 32'(up_a.ready), 32'(tbl[i].er));
      chk($sformatf("vec%0d_stall_cnt", i), 32'(cnt_a), 32'(tbl[i].en));
      check_model();
      model_edge();
      @(posedge clk);
      #1;
    end

    // saturation of the 4-bit counter, then flush must leave it saturated
    rst       = 1'b0;
    flush     = 1'b0;
    src_valid = 1'b1;
    src_data  = 16'h0031;
    src_ctrl  = 8'h31;
    snk_ready = 1'b0;
    repeat (22) step();
    flush = 1'b1;
    @(negedge clk);
    check_model();
    chk("sat_before_flush", 32'(cnt_b), 32'h0000000F);
    model_edge();
    @(posedge clk);
    #1;
    flush     = 1'b0;
    src_valid = 1'b0;
    @(negedge clk);
    check_model();
    chk("sat_after_flush", 32'(cnt_b), 32'h0000000F);
    chk("flush_bubble_ctrl", 32'(dn_a.ctrl), 32'h0);
    model_edge();
    @(posedge clk);
    #1;

    // randomized traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      src_valid = ($urandom_range(0, 3) != 0);
      snk_ready = (i < 1500) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 1) != 0);
      src_data  = 16'($urandom);
      src_ctrl  = 8'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
